// File: rtl/mem_bus_ctrl_if.sv
// Request/response bundle between the pipeline (data-memory and fetch stages)
// and the ThinPad SRAM/UART bus controller.
interface mem_bus_ctrl_if;
  logic [15:0] DataAddress;
  logic [15:0] DataWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic        AddressSrc;
  logic [15:0] InstAddress;
  logic        InstReq;
  logic [15:0] DataReadData;
  logic        DataAck;
  logic [15:0] InstData;
  logic        InstAck;
  logic        Busy;

  modport master (
    output DataAddress, DataWriteData, MemRead, MemWrite, AddressSrc,
    output InstAddress, InstReq,
    input  DataReadData, DataAck, InstData, InstAck, Busy
  );

  modport slave (
    input  DataAddress, DataWriteData, MemRead, MemWrite, AddressSrc,
    input  InstAddress, InstReq,
    output DataReadData, DataAck, InstData, InstAck, Busy
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// ThinPad Ram1/Ram2 bus controller: one access engine, data-over-fetch priority,
// fixed SETUP/STROBE/DONE sequence. Define UART_MMIO_EN to decode 0xBF00/0xBF01 as UART.
module mem_bus_ctrl (
  input  logic          clk,
  input  logic          rst,
  mem_bus_ctrl_if.slave bus,
  output logic [17:0]   Ram1Addr,
  output logic [17:0]   Ram2Addr,
  inout  wire  [15:0]   Ram1Data,
  inout  wire  [15:0]   Ram2Data,
  output logic          Ram1EN,
  output logic          Ram1OE,
  output logic          Ram1WE,
  output logic          Ram2EN,
  output logic          Ram2OE,
  output logic          Ram2WE,
  output logic          rdn,
  output logic          wrn,
  input  logic          data_ready,
  input  logic          tbre,
  input  logic          tsre
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t      state;
  state_t      state_nxt;

  logic        req_wr;
  logic        req_inst;
  logic        req_tgt1;
  logic        req_tgt2;
  logic        req_uart;
  logic        req_stat;
  logic [15:0] req_wdata;

  logic        data_req;
  logic        dec_uart;
  logic        dec_stat;
  logic [15:0] stat_word;
  logic        drv1;
  logic        drv2;

  assign data_req = bus.MemRead | bus.MemWrite;

`ifdef UART_MMIO_EN
  assign dec_uart  = (bus.DataAddress == 16'hBF00);
  assign dec_stat  = (bus.DataAddress == 16'hBF01);
  assign stat_word = {14'b0, data_ready, tbre & tsre};
`else
  logic unused_uart;
  assign dec_uart    = 1'b0;
  assign dec_stat    = 1'b0;
  assign stat_word   = 16'h0000;
  assign unused_uart = ^{data_ready, tbre, tsre};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_req || bus.InstReq) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and read capture; the MMIO decode wins over AddressSrc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_wr           <= 1'b0;
      req_inst         <= 1'b0;
      req_tgt1         <= 1'b0;
      req_tgt2         <= 1'b0;
      req_uart         <= 1'b0;
      req_stat         <= 1'b0;
      Ram1Addr         <= 18'h0;
      Ram2Addr         <= 18'h0;
      bus.DataReadData <= 16'h0;
      bus.InstData     <= 16'h0;
    end else begin
      if (state == IDLE) begin
        if (data_req) begin
          req_wr   <= ~bus.MemRead;
          req_inst <= 1'b0;
          req_uart <= dec_uart;
          req_stat <= dec_stat;
          req_tgt1 <= ~dec_uart & ~dec_stat & ~bus.AddressSrc;
          req_tgt2 <= ~dec_uart & ~dec_stat &  bus.AddressSrc;
          if (!dec_uart && !dec_stat) begin
            if (bus.AddressSrc) Ram2Addr <= {2'b00, bus.DataAddress};
            else                Ram1Addr <= {2'b00, bus.DataAddress};
          end
        end else if (bus.InstReq) begin
          req_wr   <= 1'b0;
          req_inst <= 1'b1;
          req_uart <= 1'b0;
          req_stat <= 1'b0;
          req_tgt1 <= 1'b0;
          req_tgt2 <= 1'b1;
          Ram2Addr <= {2'b00, bus.InstAddress};
        end
      end
      if (state == STROBE && !req_wr) begin
        if (req_inst)      bus.InstData     <= Ram2Data;
        else if (req_stat) bus.DataReadData <= stat_word;
        else if (req_tgt2) bus.DataReadData <= Ram2Data;
        else               bus.DataReadData <= Ram1Data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && data_req) req_wdata <= bus.DataWriteData;
  end

  always_comb begin
    Ram1EN      = 1'b1;
    Ram1OE      = 1'b1;
    Ram1WE      = 1'b1;
    Ram2EN      = 1'b1;
    Ram2OE      = 1'b1;
    Ram2WE      = 1'b1;
    rdn         = 1'b1;
    wrn         = 1'b1;
    drv1        = 1'b0;
    drv2        = 1'b0;
    bus.DataAck = 1'b0;
    bus.InstAck = 1'b0;
    bus.Busy    = (state != IDLE);
    case (state)
      SETUP: begin
        Ram1EN = ~req_tgt1;
        Ram2EN = ~req_tgt2;
        drv1   = req_wr & (req_tgt1 | req_uart);
        drv2   = req_wr & req_tgt2;
      end
      STROBE: begin
        Ram1EN = ~req_tgt1;
        Ram2EN = ~req_tgt2;
        drv1   = req_wr & (req_tgt1 | req_uart);
        drv2   = req_wr & req_tgt2;
        Ram1OE = ~(req_tgt1 & ~req_wr);
        Ram1WE = ~(req_tgt1 &  req_wr);
        Ram2OE = ~(req_tgt2 & ~req_wr);
        Ram2WE = ~(req_tgt2 &  req_wr);
`ifdef UART_MMIO_EN
        rdn    = ~(req_uart & ~req_wr);
        wrn    = ~(req_uart &  req_wr);
`endif
      end
      DONE: begin
        // Write data held one more cycle past the rising WE for hold time.
        drv1        = req_wr & (req_tgt1 | req_uart);
        drv2        = req_wr & req_tgt2;
        bus.DataAck = ~req_inst;
        bus.InstAck =  req_inst;
      end
      default: ;
    endcase
  end

  assign Ram1Data = drv1 ? req_wdata : 16'hzzzz;
  assign Ram2Data = drv2 ? req_wdata : 16'hzzzz;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with behavioural Ram1/Ram2 SRAM models.
module tb_mem_bus_ctrl;
  logic        clk;
  logic        rst;
  logic [17:0] Ram1Addr;
  logic [17:0] Ram2Addr;
  wire  [15:0] ram1_data;
  wire  [15:0] ram2_data;
  logic        Ram1EN, Ram1OE, Ram1WE, Ram2EN, Ram2OE, Ram2WE;
  logic        rdn, wrn;
  logic        data_ready, tbre, tsre;

  logic        pl_en;
  logic        pl_sel;
  logic [15:0] pl_addr;
  logic [15:0] pl_data;

  logic [15:0] mem1 [0:65535];
  logic [15:0] mem2 [0:65535];

  int checks;
  int errors;

  mem_bus_ctrl_if bus ();

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .Ram1Addr(Ram1Addr), .Ram2Addr(Ram2Addr),
    .Ram1Data(ram1_data), .Ram2Data(ram2_data),
    .Ram1EN(Ram1EN), .Ram1OE(Ram1OE), .Ram1WE(Ram1WE),
    .Ram2EN(Ram2EN), .Ram2OE(Ram2OE), .Ram2WE(Ram2WE),
    .rdn(rdn), .wrn(wrn),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram1_data = (!Ram1EN && !Ram1OE) ? mem1[Ram1Addr[15:0]] : 16'hzzzz;
  assign ram2_data = (!Ram2EN && !Ram2OE) ? mem2[Ram2Addr[15:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (pl_en) begin
      if (pl_sel) mem2[pl_addr] <= pl_data;
      else        mem1[pl_addr] <= pl_data;
    end
    if (!Ram1EN && !Ram1WE) mem1[Ram1Addr[15:0]] <= ram1_data;
    if (!Ram2EN && !Ram2WE) mem2[Ram2Addr[15:0]] <= ram2_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk18(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic sel, input logic [15:0] a, input logic [15:0] d);
    pl_en   = 1'b1;
    pl_sel  = sel;
    pl_addr = a;
    pl_data = d;
    step();
    pl_en   = 1'b0;
  endtask

  task automatic data_req(input logic rd, input logic wr, input logic src,
                          input logic [15:0] a, input logic [15:0] d);
    bus.MemRead       = rd;
    bus.MemWrite      = wr;
    bus.AddressSrc    = src;
    bus.DataAddress   = a;
    bus.DataWriteData = d;
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst               = 1'b0;
    pl_en             = 1'b0;
    pl_sel            = 1'b0;
    pl_addr           = 16'h0;
    pl_data           = 16'h0;
    data_ready        = 1'b1;
    tbre              = 1'b1;
    tsre              = 1'b0;
    bus.InstAddress   = 16'h0;
    bus.InstReq       = 1'b0;
    data_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    preload(1'b1, 16'h0040, 16'hBEEF);
    preload(1'b1, 16'h0010, 16'h1010);
    preload(1'b1, 16'h0020, 16'hC0DE);
    preload(1'b1, 16'hBF01, 16'h7777);
    preload(1'b0, 16'h0030, 16'h1111);
    preload(1'b0, 16'h0008, 16'h0808);
    preload(1'b0, 16'h1234, 16'h0000);

    chk1 ("rst_busy", bus.Busy, 1'b0);
    chk1 ("rst_dack", bus.DataAck, 1'b0);
    chk1 ("rst_iack", bus.InstAck, 1'b0);
    chk1 ("rst_r1en", Ram1EN, 1'b1);
    chk1 ("rst_r2en", Ram2EN, 1'b1);
    chk1 ("rst_r1we", Ram1WE, 1'b1);
    chk1 ("rst_r2oe", Ram2OE, 1'b1);
    chk1 ("rst_rdn", rdn, 1'b1);
    chk1 ("rst_wrn", wrn, 1'b1);
    chk18("rst_r1addr", Ram1Addr, 18'h0);
    chk18("rst_r2addr", Ram2Addr, 18'h0);
    chk16("rst_drd", bus.DataReadData, 16'h0);
    chk16("rst_inst", bus.InstData, 16'h0);
    rst = 1'b1;
    step();

    // Ram2 read of 0x0040
    data_req(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0);
    step();
    chk18("rd2_addr", Ram2Addr, 18'h00040);
    chk1 ("rd2_c1_en", Ram2EN, 1'b0);
    chk1 ("rd2_c1_oe", Ram2OE, 1'b1);
    chk1 ("rd2_c1_busy", bus.Busy, 1'b1);
    step();
    chk1 ("rd2_c2_oe", Ram2OE, 1'b0);
    chk1 ("rd2_c2_r1en", Ram1EN, 1'b1);
    chk1 ("rd2_c2_ack", bus.DataAck, 1'b0);
    step();
    chk1 ("rd2_c3_ack", bus.DataAck, 1'b1);
    chk1 ("rd2_c3_oe", Ram2OE, 1'b1);
    chk1 ("rd2_c3_en", Ram2EN, 1'b1);
    chk16("rd2_data", bus.DataReadData, 16'hBEEF);
    bus.MemRead = 1'b0;
    step();
    chk1 ("rd2_c4_ack", bus.DataAck, 1'b0);
    chk1 ("rd2_c4_busy", bus.Busy, 1'b0);

    // Ram1 write 0x5A5A to 0x1234
    data_req(1'b0, 1'b1, 1'b0, 16'h1234, 16'h5A5A);
    step();
    chk1 ("wr1_c1_we", Ram1WE, 1'b1);
    chk1 ("wr1_c1_en", Ram1EN, 1'b0);
    chk16("wr1_c1_bus", ram1_data, 16'h5A5A);
    step();
    chk1 ("wr1_c2_we", Ram1WE, 1'b0);
    chk16("wr1_c2_bus", ram1_data, 16'h5A5A);
    chk1 ("wr1_c2_r2en", Ram2EN, 1'b1);
    chk1 ("wr1_c2_r2we", Ram2WE, 1'b1);
    chk1 ("wr1_c2_r2oe", Ram2OE, 1'b1);
    step();
    chk1 ("wr1_c3_we", Ram1WE, 1'b1);
    chk1 ("wr1_c3_ack", bus.DataAck, 1'b1);
    bus.MemWrite = 1'b0;
    step();
    chk16("wr1_mem", mem1[16'h1234], 16'h5A5A);
    chk18("wr1_r2addr", Ram2Addr, 18'h00040);

    // Data read and fetch in the same cycle: data first
    data_req(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0);
    bus.InstAddress = 16'h0020;
    bus.InstReq     = 1'b1;
    step();
    chk18("cf_c1_addr", Ram2Addr, 18'h00010);
    step();
    step();
    chk1 ("cf_c3_dack", bus.DataAck, 1'b1);
    chk1 ("cf_c3_iack", bus.InstAck, 1'b0);
    chk16("cf_c3_data", bus.DataReadData, 16'h1010);
    bus.MemRead = 1'b0;
    step();
    chk1 ("cf_c4_busy", bus.Busy, 1'b0);
    step();
    chk18("cf_c5_addr", Ram2Addr, 18'h00020);
    chk1 ("cf_c5_busy", bus.Busy, 1'b1);
    step();
    chk1 ("cf_c6_oe", Ram2OE, 1'b0);
    step();
    chk1 ("cf_c7_iack", bus.InstAck, 1'b1);
    chk1 ("cf_c7_dack", bus.DataAck, 1'b0);
    chk16("cf_c7_inst", bus.InstData, 16'hC0DE);
    chk16("cf_c7_dhold", bus.DataReadData, 16'h1010);
    bus.InstReq = 1'b0;
    step();

    // Reset during STROBE of a Ram1 write
    data_req(1'b0, 1'b1, 1'b0, 16'h0030, 16'hDEAD);
    step();
    step();
    chk1 ("ra_c2_we", Ram1WE, 1'b0);
    rst = 1'b0;
    #1;
    chk1 ("ra_we", Ram1WE, 1'b1);
    chk1 ("ra_en", Ram1EN, 1'b1);
    chk1 ("ra_busy", bus.Busy, 1'b0);
    chk1 ("ra_ack", bus.DataAck, 1'b0);
    chk16("ra_drd", bus.DataReadData, 16'h0);
    chk16("ra_inst", bus.InstData, 16'h0);
    bus.MemWrite = 1'b0;
    step();
    chk1 ("ra_ack2", bus.DataAck, 1'b0);
    rst = 1'b1;
    step();
    chk16("ra_mem", mem1[16'h0030], 16'h1111);
    data_req(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
    step();
    step();
    step();
    chk1 ("ra_rd_ack", bus.DataAck, 1'b1);
    chk16("ra_rd_data", bus.DataReadData, 16'h1111);
    bus.MemRead = 1'b0;
    step();

    // MemRead and MemWrite together: read only
    data_req(1'b1, 1'b1, 1'b0, 16'h0008, 16'hFFFF);
    step();
    chk1 ("rw_c1_we", Ram1WE, 1'b1);
    step();
    chk1 ("rw_c2_we", Ram1WE, 1'b1);
    chk1 ("rw_c2_oe", Ram1OE, 1'b0);
    step();
    chk1 ("rw_c3_we", Ram1WE, 1'b1);
    chk1 ("rw_c3_ack", bus.DataAck, 1'b1);
    chk16("rw_data", bus.DataReadData, 16'h0808);
    data_req(1'b0, 1'b0, 1'b0, 16'h0008, 16'h0);
    step();
    chk16("rw_mem", mem1[16'h0008], 16'h0808);

`ifdef UART_MMIO_EN
    // Status read at 0xBF01 (decode wins over AddressSrc)
    data_req(1'b1, 1'b0, 1'b1, 16'hBF01, 16'h0);
    step();
    chk1 ("st_c1_r1en", Ram1EN, 1'b1);
    chk1 ("st_c1_r2en", Ram2EN, 1'b1);
    step();
    chk1 ("st_c2_rdn", rdn, 1'b1);
    chk1 ("st_c2_r2oe", Ram2OE, 1'b1);
    step();
    chk1 ("st_c3_ack", bus.DataAck, 1'b1);
    chk16("st_data", bus.DataReadData, 16'h0002);
    bus.MemRead = 1'b0;
    step();

    // UART transmit write at 0xBF00
    data_req(1'b0, 1'b1, 1'b1, 16'hBF00, 16'h0041);
    step();
    chk1 ("tx_c1_wrn", wrn, 1'b1);
    chk1 ("tx_c1_r1en", Ram1EN, 1'b1);
    chk16("tx_c1_bus", ram1_data, 16'h0041);
    step();
    chk1 ("tx_c2_wrn", wrn, 1'b0);
    chk1 ("tx_c2_r1en", Ram1EN, 1'b1);
    chk1 ("tx_c2_r1we", Ram1WE, 1'b1);
    chk1 ("tx_c2_r2we", Ram2WE, 1'b1);
    chk16("tx_c2_bus", ram1_data, 16'h0041);
    step();
    chk1 ("tx_c3_wrn", wrn, 1'b1);
    chk1 ("tx_c3_ack", bus.DataAck, 1'b1);
    bus.MemWrite = 1'b0;
    step();
`else
    // Without MMIO, 0xBF01/0xBF00 are plain memory
    data_req(1'b1, 1'b0, 1'b1, 16'hBF01, 16'h0);
    step();
    chk1 ("bf1_c1_en", Ram2EN, 1'b0);
    chk18("bf1_addr", Ram2Addr, 18'h0BF01);
    step();
    chk1 ("bf1_c2_rdn", rdn, 1'b1);
    chk1 ("bf1_c2_oe", Ram2OE, 1'b0);
    step();
    chk16("bf1_data", bus.DataReadData, 16'h7777);
    bus.MemRead = 1'b0;
    step();
    data_req(1'b0, 1'b1, 1'b0, 16'hBF00, 16'h0041);
    step();
    step();
    chk1 ("bf0_c2_wrn", wrn, 1'b1);
    chk1 ("bf0_c2_we", Ram1WE, 1'b0);
    step();
    bus.MemWrite = 1'b0;
    step();
    chk16("bf0_mem", mem1[16'hBF00], 16'h0041);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
